// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - datapath <-> control unit bus for the RV32I multicycle core
interface mc_control_fsm_if;
  logic [31:0] instr;
  logic        Zero;
  logic        cout;
  logic        overflow;
  logic        sign;
  logic        mem_ready;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic        instr_retired;
  logic        illegal;

  modport master (
    output instr, Zero, cout, overflow, sign, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, instr_retired, illegal
  );

  modport slave (
    input  instr, Zero, cout, overflow, sign, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, instr_retired, illegal
  );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - RV32I multicycle control FSM
// MC_ILLEGAL_TRAP_EN: illegal encodings park in TRAP with a sticky illegal flag
module mc_control_fsm (
  input logic             clk,
  input logic             reset,
  mc_control_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000, ALU_SRA = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT   = S_TRAP;
  localparam logic   ILLEGAL_RETIRE = 1'b0;
`else
  localparam state_t ILLEGAL_NEXT   = S_FETCH;
  localparam logic   ILLEGAL_RETIRE = 1'b1;
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7b5          = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  state_t     state, state_n;
  logic [2:0] imm_dec;
  logic [3:0] alu_dec;
  logic       br_taken;
  logic       br_legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    imm_dec = IMM_I;
    case (opcode)
      OP_STORE:         imm_dec = IMM_S;
      OP_BR:            imm_dec = IMM_B;
      OP_JAL:           imm_dec = IMM_J;
      OP_LUI, OP_AUIPC: imm_dec = IMM_U;
      default:          imm_dec = IMM_I;
    endcase
  end

  // funct7b5 selects sub only for register-register ops; addi ignores it
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (funct7b5 && state == S_EXECR) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = bus.Zero;
      3'b001:  br_taken = !bus.Zero;
      3'b100:  br_taken = bus.sign ^ bus.overflow;
      3'b101:  br_taken = !(bus.sign ^ bus.overflow);
      3'b110:  br_taken = !bus.cout;
      3'b111:  br_taken = bus.cout;
      default: br_taken = 1'b0;
    endcase
  end

  assign br_legal = (funct3[2:1] != 2'b01);

  always_comb begin
    state_n           = state;
    bus.PCWrite       = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.AdrSrc        = 1'b0;
    bus.ALUSrcA       = 2'b00;
    bus.ALUSrcB       = 2'b00;
    bus.ResultSrc     = 2'b00;
    bus.ImmSrc        = imm_dec;
    bus.ALUControl    = ALU_ADD;
    bus.instr_retired = 1'b0;
    case (state)
      S_FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = bus.mem_ready;
        bus.IRWrite   = bus.mem_ready;
        if (bus.mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_n = S_MEMADR;
          OP_R:              state_n = S_EXECR;
          OP_I:              state_n = S_EXECI;
          OP_JAL:            state_n = S_JAL;
          OP_JALR:           state_n = S_JALR;
          OP_LUI:            state_n = S_LUI;
          OP_AUIPC:          state_n = S_ALUWB;
          OP_FENCE, OP_SYS: begin
            state_n           = S_FETCH;
            bus.instr_retired = 1'b1;
          end
          OP_BR: begin
            state_n           = br_legal ? S_BRANCH : ILLEGAL_NEXT;
            bus.instr_retired = br_legal ? 1'b0 : ILLEGAL_RETIRE;
          end
          default: begin
            state_n           = ILLEGAL_NEXT;
            bus.instr_retired = ILLEGAL_RETIRE;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        bus.ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_n     = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc     = 2'b01;
        bus.RegWrite      = 1'b1;
        bus.instr_retired = 1'b1;
        state_n           = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc        = 1'b1;
        bus.MemWrite      = 1'b1;
        bus.instr_retired = bus.mem_ready;
        if (bus.mem_ready) state_n = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
        bus.ALUControl = alu_dec;
        state_n        = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite      = 1'b1;
        bus.instr_retired = 1'b1;
        state_n           = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA       = 2'b10;
        bus.ALUControl    = ALU_SUB;
        bus.PCWrite       = br_taken;
        bus.instr_retired = 1'b1;
        state_n           = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_n     = S_ALUWB;
      end
      S_JALR: begin
        bus.ALUSrcA   = 2'b10;
        bus.ALUSrcB   = 2'b01;
        bus.ImmSrc    = IMM_I;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
        state_n       = S_LINK;
      end
      S_LINK: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        state_n     = S_ALUWB;
      end
      S_LUI: begin
        bus.ImmSrc        = IMM_U;
        bus.ResultSrc     = 2'b11;
        bus.RegWrite      = 1'b1;
        bus.instr_retired = 1'b1;
        state_n           = S_FETCH;
      end
      default: state_n = S_TRAP;
    endcase
    // reset forces FETCH asynchronously; also mask the ready-gated fetch enables
    if (reset) begin
      bus.PCWrite       = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.instr_retired = 1'b0;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal = (state == S_TRAP);
`else
  assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm with a per-instruction reference model
module tb_mc_control_fsm;
  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       adr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ret;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_control_fsm_if bus ();
  mc_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  int    errs   = 0;
  int    checks = 0;
  ctl_t  exp_q[$];
  string tag_q[$];

`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == 7'h23) return 3'd1;
    if (op == 7'h63) return 3'd2;
    if (op == 7'h6f) return 3'd3;
    if (op == 7'h37 || op == 7'h17) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7b5, input bit is_r);
    logic [3:0] r;
    case (f3)
      3'd0: r = (is_r && f7b5) ? 4'd1 : 4'd0;
      3'd1: r = 4'd7;
      3'd2: r = 4'd5;
      3'd3: r = 4'd6;
      3'd4: r = 4'd4;
      3'd5: r = f7b5 ? 4'd9 : 4'd8;
      3'd6: r = 4'd3;
      default: r = 4'd2;
    endcase
    return r;
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic c, input logic s, input logic v);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return s != v;
      3'd5: return s == v;
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctl_t dflt(input logic [31:0] ins);
    ctl_t c;
    c = '0;
    c.imm = imm_of(ins[6:0]);
    return c;
  endfunction

  function automatic ctl_t fetch_exp(input logic [31:0] ins, input logic en);
    ctl_t c;
    c = dflt(ins);
    c.sb = 2'b10;
    c.rs = 2'b10;
    c.pcw = en;
    c.irw = en;
    return c;
  endfunction

  task automatic rand_flags();
    bus.Zero = 1'($urandom);
    bus.cout = 1'($urandom);
    bus.overflow = 1'($urandom);
    bus.sign = 1'($urandom);
  endtask

  task automatic step(input ctl_t e, input logic mr, input string tag);
    bus.mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    rand_flags();
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step(fetch_exp(bus.instr, 1'b0), 1'b1, "reset");
    reset = 1'b0;
  endtask

  // flag_ovr >= 0 forces {Zero,cout} for the branch-resolve cycle
  task automatic do_instr(input logic [31:0] ins, input int fw, input int mwait, input int flag_ovr);
    logic [6:0] op;
    logic [2:0] f3;
    bit   legal;
    bit   nop;
    ctl_t c;
    op = ins[6:0];
    f3 = ins[14:12];
    bus.instr = ins;
    nop = (op == 7'h0f || op == 7'h73);
    legal = (op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17}) || nop;
    if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3)) legal = 0;
    for (int i = 0; i < fw; i++) step(fetch_exp(ins, 1'b0), 1'b0, "fetch_wait");
    step(fetch_exp(ins, 1'b1), 1'b1, "fetch");
    c = dflt(ins); c.sa = 2'b01; c.sb = 2'b01;
    c.ret = nop || (!legal && !TRAP_EN);
    step(c, 1'($urandom), "decode");
    if (!legal && TRAP_EN) begin
      for (int i = 0; i < 3; i++) begin
        c = dflt(ins); c.ill = 1'b1;
        step(c, 1'($urandom), "trap");
      end
      reset_cycles(1);
      return;
    end
    if (nop || !legal) return;
    case (op)
      7'h03, 7'h23: begin
        c = dflt(ins); c.sa = 2'b10; c.sb = 2'b01; c.imm = (op == 7'h23) ? 3'd1 : 3'd0;
        step(c, 1'($urandom), "memadr");
        c = dflt(ins); c.adr = 1'b1; c.mw = (op == 7'h23);
        for (int i = 0; i < mwait; i++) step(c, 1'b0, "mem_wait");
        c.ret = (op == 7'h23);
        step(c, 1'b1, "mem_done");
        if (op == 7'h03) begin
          c = dflt(ins); c.rs = 2'b01; c.rw = 1'b1; c.ret = 1'b1;
          step(c, 1'($urandom), "memwb");
        end
      end
      7'h33, 7'h13, 7'h17: begin
        if (op != 7'h17) begin
          c = dflt(ins); c.sa = 2'b10; c.sb = (op == 7'h13) ? 2'b01 : 2'b00;
          c.alu = alu_of(f3, ins[30], op == 7'h33);
          step(c, 1'($urandom), "exec");
        end
        c = dflt(ins); c.rw = 1'b1; c.ret = 1'b1;
        step(c, 1'($urandom), "aluwb");
      end
      7'h63: begin
        if (flag_ovr >= 0) begin
          bus.Zero = flag_ovr[1];
          bus.cout = flag_ovr[0];
        end
        c = dflt(ins); c.sa = 2'b10; c.alu = 4'd1; c.ret = 1'b1;
        c.pcw = taken_of(f3, bus.Zero, bus.cout, bus.sign, bus.overflow);
        step(c, 1'($urandom), "branch");
      end
      7'h6f, 7'h67: begin
        c = dflt(ins); c.pcw = 1'b1;
        if (op == 7'h6f) begin
          c.sa = 2'b01; c.sb = 2'b10;
          step(c, 1'($urandom), "jal");
        end else begin
          c.sa = 2'b10; c.sb = 2'b01; c.imm = 3'd0; c.rs = 2'b10;
          step(c, 1'($urandom), "jalr");
          c = dflt(ins); c.sa = 2'b01; c.sb = 2'b10;
          step(c, 1'($urandom), "link");
        end
        c = dflt(ins); c.rw = 1'b1; c.ret = 1'b1;
        step(c, 1'($urandom), "aluwb");
      end
      default: begin
        c = dflt(ins); c.imm = 3'd4; c.rs = 2'b11; c.rw = 1'b1; c.ret = 1'b1;
        step(c, 1'($urandom), "lui");
      end
    endcase
  endtask

  always @(negedge clk) begin
    ctl_t  e;
    ctl_t  a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc, bus.ALUSrcA,
           bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl, bus.instr_retired, bus.illegal};
      checks++;
      if (a !== e) begin
        errs++;
        $display("FAIL %s instr=%h: got pcw%b irw%b rw%b mw%b adr%b sa%b sb%b rs%b imm%b alu%b ret%b ill%b, want pcw%b irw%b rw%b mw%b adr%b sa%b sb%b rs%b imm%b alu%b ret%b ill%b",
                 t, bus.instr, a.pcw, a.irw, a.rw, a.mw, a.adr, a.sa, a.sb, a.rs, a.imm, a.alu, a.ret, a.ill,
                 e.pcw, e.irw, e.rw, e.mw, e.adr, e.sa, e.sb, e.rs, e.imm, e.alu, e.ret, e.ill);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] ins;
    ctl_t        c;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73, 7'h7f};
    reset = 1'b1;
    bus.instr = 32'h0;
    bus.mem_ready = 1'b1;
    rand_flags();
    @(posedge clk);
    #1;
    reset_cycles(2);

    do_instr(32'h00500093, 0, 0, -1);
    do_instr(32'h40208033, 0, 0, -1);
    do_instr(32'h4020D013, 0, 0, -1);
    do_instr(32'h00208463, 0, 0, 2);
    do_instr(32'h0020e463, 0, 0, 1);
    do_instr(32'h0000a083, 0, 2, -1);
    do_instr(32'h0010a023, 1, 1, -1);
    do_instr(32'h000080e7, 0, 0, -1);
    do_instr(32'h000010b7, 0, 0, -1);
    do_instr(32'h00001097, 0, 0, -1);
    do_instr(32'h0000007F, 0, 0, -1);
    do_instr(32'h0020a463, 0, 0, -1);

    // reset landing in the middle of a store wait must drop MemWrite immediately
    bus.instr = 32'h0010a023;
    step(fetch_exp(bus.instr, 1'b1), 1'b1, "fetch");
    c = dflt(bus.instr); c.sa = 2'b01; c.sb = 2'b01;
    step(c, 1'b1, "decode");
    c = dflt(bus.instr); c.sa = 2'b10; c.sb = 2'b01; c.imm = 3'd1;
    step(c, 1'b1, "memadr");
    c = dflt(bus.instr); c.adr = 1'b1; c.mw = 1'b1;
    bus.mem_ready = 1'b0;
    exp_q.push_back(c);
    tag_q.push_back("memwrite_pre_reset");
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0 || bus.AdrSrc !== 1'b0) begin
      errs++;
      $display("FAIL async_reset_memwrite: got MemWrite=%b AdrSrc=%b, want 0 0", bus.MemWrite, bus.AdrSrc);
    end
    @(posedge clk);
    #1;
    reset_cycles(2);

    for (int n = 0; n < 250; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
